// File: rtl/sha256_wb_initiator_pkg.sv
// Shared constants and types for the SHA-256 Wishbone initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: core register word indices, STATUS bit positions, CTRL commands, FSM state enum.
package sha256_wb_pkg;

  // Core register map, as word indices placed on wbm_adr_o[7:0]
  localparam logic [7:0] REG_CTRL        = 8'h08;
  localparam logic [7:0] REG_STATUS      = 8'h09;
  localparam logic [7:0] REG_BLOCK_BASE  = 8'h10;
  localparam logic [7:0] REG_DIGEST_BASE = 8'h20;

  // STATUS register bits
  localparam int STATUS_READY_BIT  = 0;
  localparam int STATUS_DVALID_BIT = 1;

  // CTRL command values
  localparam logic [31:0] CTRL_INIT = 32'h0000_0001;
  localparam logic [31:0] CTRL_NEXT = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_RDY,
    ST_WR_BLK,
    ST_WR_CTRL,
    ST_POLL_DIG,
    ST_RD_DIG,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/sha256_wb_initiator_if.sv
// Wishbone classic master bus bundle between the initiator and the SHA-256 responder.
// Latency: n/a (wires only).
// Backpressure: responder stalls the master by withholding wbm_ack_i.
// Ports: master drives cyc/stb/we/adr/dat/sel and samples dat_i/ack; slave is the mirror.
interface sha256_wb_initiator_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/sha256_wb_initiator_wb_master_port.sv
// Single Wishbone classic transfer engine: registers a request onto the bus and waits for ack.
// Latency: stb rises on the edge that samples req_i; done_o is combinational with the ack cycle.
// Backpressure: holds the transfer until ack or until ACK_TIMEOUT cycles of stb elapse.
// Ports: clk_i/rst_i; req_i/we_i/idx_i/wdat_i request; active_o, done_o, timeout_o status; wbm bus.
module wb_master_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  idx_i,
  input  logic [31:0] wdat_i,
  output logic        active_o,
  output logic        done_o,
  output logic        timeout_o,
  sha256_wb_initiator_if.master wbm
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic          cyc_q;
  logic          stb_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [CW-1:0] tmo_cnt_q;

  // An ack on the final allowed cycle completes the transfer instead of timing out.
  assign done_o    = stb_q & wbm.wbm_ack_i;
  assign timeout_o = stb_q & ~wbm.wbm_ack_i & (tmo_cnt_q == CW'(ACK_TIMEOUT - 1));
  assign active_o  = stb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      tmo_cnt_q <= '0;
    end else if (stb_q) begin
      if (done_o || timeout_o) begin
        // Dropping here and only re-arming from the idle branch guarantees
        // one idle cycle between transfers.
        cyc_q     <= 1'b0;
        stb_q     <= 1'b0;
        we_q      <= 1'b0;
        adr_q     <= '0;
        dat_q     <= '0;
        sel_q     <= '0;
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end else if (req_i) begin
      cyc_q     <= 1'b1;
      stb_q     <= 1'b1;
      we_q      <= we_i;
      adr_q     <= BASE_ADDR | {24'h0, idx_i};
      dat_q     <= we_i ? wdat_i : 32'h0;
      sel_q     <= 4'hF;
      tmo_cnt_q <= '0;
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;

endmodule

// File: rtl/sha256_wb_initiator.sv
// Wishbone initiator that pushes one 16-word block into the SHA-256 core and streams the digest out.
// Latency: first STATUS read starts on the start edge; digest words follow their DIGEST acks by one edge.
// Backpressure: blk_ready_o only while in block-write phase with no transfer pending; digest has none.
// Ports: wb_clk_i/wb_rst_i; start_i/first_i; blk_* input stream; dig_* output stream; busy_o/error_o; wbm bus.
module sha256_wb_initiator
  import sha256_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          POLL_LIMIT  = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        first_i,
  input  logic [31:0] blk_data_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] dig_data_o,
  output logic        dig_valid_o,
  output logic        dig_last_o,
  output logic        busy_o,
  output logic        error_o,
  sha256_wb_initiator_if.master wbm
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  state_t        state_q;
  logic [3:0]    idx_q;
  logic          first_q;
  logic [31:0]   blk_q;
  logic          blk_pend_q;
  logic [PW-1:0] poll_cnt_q;
  logic          busy_q;
  logic          error_q;
  logic          dig_valid_q;
  logic          dig_last_q;
  logic [31:0]   dig_data_q;

  logic          req_d;
  logic          req_we_d;
  logic [7:0]    req_idx_d;
  logic [31:0]   req_wdat_d;
  logic          port_active;
  logic          port_done;
  logic          port_tmo;
  logic          blk_accept;
  logic          poll_last;

  // A word is taken only when the previous one has been written out.
  assign blk_ready_o = (state_q == ST_WR_BLK) && !port_active && !blk_pend_q;
  assign blk_accept  = blk_ready_o && blk_valid_i;
  assign poll_last   = (poll_cnt_q == PW'(POLL_LIMIT - 1));

  // Request decode is combinational so the first STATUS read launches on the start edge.
  always_comb begin
    req_d      = 1'b0;
    req_we_d   = 1'b0;
    req_idx_d  = REG_STATUS;
    req_wdat_d = 32'h0;
    case (state_q)
      ST_IDLE:     req_d = start_i;
      ST_POLL_RDY: req_d = 1'b1;
      ST_POLL_DIG: req_d = 1'b1;
      ST_WR_BLK: begin
        req_d      = blk_pend_q;
        req_we_d   = 1'b1;
        req_idx_d  = REG_BLOCK_BASE | {4'h0, idx_q};
        req_wdat_d = blk_q;
      end
      ST_WR_CTRL: begin
        req_d      = 1'b1;
        req_we_d   = 1'b1;
        req_idx_d  = REG_CTRL;
        req_wdat_d = first_q ? CTRL_INIT : CTRL_NEXT;
      end
      ST_RD_DIG: begin
        req_d     = 1'b1;
        req_idx_d = REG_DIGEST_BASE | {5'h0, idx_q[2:0]};
      end
      default: req_d = 1'b0;
    endcase
  end

  wb_master_port #(
    .BASE_ADDR   (BASE_ADDR),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_port (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .req_i     (req_d),
    .we_i      (req_we_d),
    .idx_i     (req_idx_d),
    .wdat_i    (req_wdat_d),
    .active_o  (port_active),
    .done_o    (port_done),
    .timeout_o (port_tmo),
    .wbm       (wbm)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      first_q     <= 1'b0;
      blk_q       <= '0;
      blk_pend_q  <= 1'b0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_last_q  <= 1'b0;
      dig_data_q  <= '0;
    end else begin
      dig_valid_q <= 1'b0;
      dig_last_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_POLL_RDY;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            first_q    <= first_i;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            blk_pend_q <= 1'b0;
          end
        end
        ST_POLL_RDY: begin
          if (port_tmo) begin
            state_q <= ST_ABORT;
          end else if (port_done) begin
            if (wbm.wbm_dat_i[STATUS_READY_BIT]) begin
              state_q    <= ST_WR_BLK;
              poll_cnt_q <= '0;
            end else if (poll_last) begin
              state_q <= ST_ABORT;
            end else begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
            end
          end
        end
        ST_WR_BLK: begin
          if (blk_accept) begin
            blk_q      <= blk_data_i;
            blk_pend_q <= 1'b1;
          end
          if (port_tmo) begin
            state_q <= ST_ABORT;
          end else if (port_done) begin
            blk_pend_q <= 1'b0;
            if (idx_q == 4'd15) begin
              idx_q   <= '0;
              state_q <= ST_WR_CTRL;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_WR_CTRL: begin
          if (port_tmo) begin
            state_q <= ST_ABORT;
          end else if (port_done) begin
            state_q    <= ST_POLL_DIG;
            poll_cnt_q <= '0;
          end
        end
        ST_POLL_DIG: begin
          if (port_tmo) begin
            state_q <= ST_ABORT;
          end else if (port_done) begin
            if (wbm.wbm_dat_i[STATUS_DVALID_BIT]) begin
              state_q    <= ST_RD_DIG;
              idx_q      <= '0;
              poll_cnt_q <= '0;
            end else if (poll_last) begin
              state_q <= ST_ABORT;
            end else begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
            end
          end
        end
        ST_RD_DIG: begin
          if (port_tmo) begin
            state_q <= ST_ABORT;
          end else if (port_done) begin
            dig_data_q  <= wbm.wbm_dat_i;
            dig_valid_q <= 1'b1;
            dig_last_q  <= (idx_q[2:0] == 3'd7);
            if (idx_q[2:0] == 3'd7) begin
              idx_q   <= '0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_ABORT: begin
          // Bus already released by the port; flag and return.
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dig_data_o  = dig_data_q;
  assign dig_valid_o = dig_valid_q;
  assign dig_last_o  = dig_last_q;
  assign busy_o      = busy_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_sha256_wb_initiator.sv
// Directed bench for sha256_wb_initiator with a behavioural SHA-256 register responder.
// Latency: n/a.
// Backpressure: responder ack latency is 0 or random 0..20; block feeder inserts gaps.
module tb_sha256_wb_initiator;
  import sha256_wb_pkg::*;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam int          ACK_TO   = 255;
  localparam int          POLL_LIM = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        first = 1'b0;
  logic [31:0] blk_data = 32'h0;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic [31:0] dig_data;
  logic        dig_valid;
  logic        dig_last;
  logic        busy;
  logic        error;

  sha256_wb_initiator_if wbm();

  sha256_wb_initiator dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start),
    .first_i     (first),
    .blk_data_i  (blk_data),
    .blk_valid_i (blk_valid),
    .blk_ready_o (blk_ready),
    .dig_data_o  (dig_data),
    .dig_valid_o (dig_valid),
    .dig_last_o  (dig_last),
    .busy_o      (busy),
    .error_o     (error),
    .wbm         (wbm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] blk_w [16];
  logic [31:0] dig_w [8];

  // Responder configuration and observations
  int          lat_mode = 0;
  bit          dv_never = 1'b0;
  logic [7:0]  noack_idx = 8'hFF;
  int          rdy_delay = 0;
  int          dv_delay = 0;
  bit          ctrl_seen = 1'b0;
  int          dig_polls = 0;
  int          noack_cycles = 0;
  int          unstable = 0;
  int          bad_bus = 0;
  logic [31:0] wr_adr [$];
  logic [31:0] wr_dat [$];
  logic [31:0] got_dig [$];
  logic        got_last [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: samples at negedge, drives ack for the following posedge.
  initial begin : responder
    bit          in_xfer;
    int          wait_left;
    logic [31:0] c_adr;
    logic [31:0] c_dat;
    logic        c_we;
    logic [7:0]  ri;
    in_xfer = 1'b0;
    wait_left = 0;
    c_adr = '0;
    c_dat = '0;
    c_we = 1'b0;
    wbm.wbm_ack_i = 1'b0;
    wbm.wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      wbm.wbm_ack_i = 1'b0;
      if (wbm.wbm_cyc_o && wbm.wbm_stb_o) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          c_adr = wbm.wbm_adr_o;
          c_dat = wbm.wbm_dat_o;
          c_we  = wbm.wbm_we_o;
          wait_left = (lat_mode != 0) ? int'($urandom_range(0, 20)) : 0;
          if (wbm.wbm_sel_o != 4'hF || c_adr[31:8] != BASE[31:8]) bad_bus++;
        end else if (wbm.wbm_adr_o != c_adr || wbm.wbm_dat_o != c_dat || wbm.wbm_we_o != c_we) begin
          unstable++;
        end
        ri = c_adr[7:0];
        if (ri == noack_idx) begin
          noack_cycles++;
        end else if (wait_left > 0) begin
          wait_left--;
        end else begin
          in_xfer = 1'b0;
          wbm.wbm_ack_i = 1'b1;
          if (c_we) begin
            wr_adr.push_back(c_adr);
            wr_dat.push_back(c_dat);
            if (ri == 8'h08) ctrl_seen = 1'b1;
          end else if (ri == 8'h09) begin
            wbm.wbm_dat_i = '0;
            if (rdy_delay > 0) rdy_delay--;
            else wbm.wbm_dat_i[0] = 1'b1;
            if (ctrl_seen) begin
              dig_polls++;
              if (!dv_never) begin
                if (dv_delay > 0) dv_delay--;
                else wbm.wbm_dat_i[1] = 1'b1;
              end
            end
          end else if (ri >= 8'h20 && ri <= 8'h27) begin
            wbm.wbm_dat_i = dig_w[ri[2:0]];
          end else begin
            wbm.wbm_dat_i = 32'hDEAD_BEEF;
          end
        end
      end else begin
        in_xfer = 1'b0;
      end
    end
  end

  initial begin : dig_monitor
    forever begin
      @(negedge clk);
      if (dig_valid) begin
        got_dig.push_back(dig_data);
        got_last.push_back(dig_last);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: time %0t reached, limit 5000000", $time);
    $fatal(1);
  end

  task automatic resp_clear();
    wr_adr.delete();
    wr_dat.delete();
    got_dig.delete();
    got_last.delete();
    rdy_delay = 2;
    dv_delay = 2;
    ctrl_seen = 1'b0;
    dig_polls = 0;
    noack_cycles = 0;
    unstable = 0;
    bad_bus = 0;
  endtask

  task automatic pulse_start(input logic f);
    @(negedge clk);
    start = 1'b1;
    first = f;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int nwords, input int max_gap);
    for (int i = 0; i < nwords; i++) begin
      int n;
      n = 0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      blk_data = blk_w[i];
      blk_valid = 1'b1;
      while (!blk_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check_eq($sformatf("feed_ready%0d", i), blk_ready, 1);
      @(negedge clk);
      blk_valid = 1'b0;
      blk_data = 32'h0;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_cyc"}, wbm.wbm_cyc_o, 0);
    check_eq({tag, "_stb"}, wbm.wbm_stb_o, 0);
    check_eq({tag, "_we"}, wbm.wbm_we_o, 0);
    check_eq({tag, "_adr"}, wbm.wbm_adr_o, 0);
    check_eq({tag, "_dat"}, wbm.wbm_dat_o, 0);
    check_eq({tag, "_sel"}, wbm.wbm_sel_o, 0);
    check_eq({tag, "_blk_ready"}, blk_ready, 0);
    check_eq({tag, "_dig_valid"}, dig_valid, 0);
    check_eq({tag, "_dig_last"}, dig_last, 0);
    check_eq({tag, "_dig_data"}, dig_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_error"}, error, 0);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] ctrl_val);
    logic [31:0] ea;
    logic [31:0] ed;
    check_eq({tag, "_nwr"}, wr_adr.size(), 17);
    for (int i = 0; i < 17 && i < wr_adr.size(); i++) begin
      ea = (i < 16) ? (BASE | (32'h10 + 32'(i))) : (BASE | 32'h08);
      ed = (i < 16) ? blk_w[i] : ctrl_val;
      check_eq($sformatf("%s_wadr%0d", tag, i), wr_adr[i], ea);
      check_eq($sformatf("%s_wdat%0d", tag, i), wr_dat[i], ed);
    end
    check_eq({tag, "_bus"}, bad_bus, 0);
  endtask

  task automatic check_digest(input string tag);
    check_eq({tag, "_ndig"}, got_dig.size(), 8);
    for (int i = 0; i < 8 && i < got_dig.size(); i++) begin
      check_eq($sformatf("%s_dig%0d", tag, i), got_dig[i], dig_w[i]);
      check_eq($sformatf("%s_last%0d", tag, i), got_last[i], (i == 7) ? 1 : 0);
    end
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < 16; i++) blk_w[i] = 32'h0;
    blk_w[0]  = 32'h6162_6380;
    blk_w[15] = 32'h0000_0018;
    dig_w[0] = 32'hba78_16bf; dig_w[1] = 32'h8f01_cfea;
    dig_w[2] = 32'h4141_40de; dig_w[3] = 32'h5dae_2223;
    dig_w[4] = 32'hb003_61a3; dig_w[5] = 32'h9617_7a9c;
    dig_w[6] = 32'hb410_ff61; dig_w[7] = 32'hf200_15ad;
    resp_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // Zero-wait responder, init command
    resp_clear();
    pulse_start(1'b1);
    check_eq("t1_busy_rise", busy, 1);
    check_eq("t1_first_stb", wbm.wbm_stb_o, 1);
    check_eq("t1_first_adr", wbm.wbm_adr_o, BASE | 32'h09);
    check_eq("t1_first_we", wbm.wbm_we_o, 0);
    feed(16, 0);
    wait_idle("t1_idle", 2000);
    check_writes("t1", 32'h1);
    check_digest("t1");
    check_eq("t1_error", error, 0);

    // Random ack latency with feeder gaps, next command
    lat_mode = 1;
    resp_clear();
    pulse_start(1'b0);
    feed(16, 4);
    wait_idle("t2_idle", 5000);
    check_writes("t2", 32'h2);
    check_digest("t2");
    check_eq("t2_stb_stable", unstable, 0);
    lat_mode = 0;

    // Digest never valid: poll limit abort
    dv_never = 1'b1;
    resp_clear();
    pulse_start(1'b1);
    feed(16, 0);
    wait_idle("t3_idle", 5000);
    check_eq("t3_dig_polls", dig_polls, POLL_LIM);
    check_eq("t3_error", error, 1);
    check_eq("t3_cyc", wbm.wbm_cyc_o, 0);
    check_eq("t3_no_digest", got_dig.size(), 0);
    dv_never = 1'b0;
    resp_clear();
    pulse_start(1'b1);
    check_eq("t3_error_clr", error, 0);
    feed(16, 0);
    wait_idle("t3b_idle", 2000);
    check_digest("t3b");

    // No ack on BLOCK5: ack timeout abort
    noack_idx = 8'h15;
    resp_clear();
    pulse_start(1'b1);
    feed(6, 0);
    wait_idle("t4_idle", 2000);
    check_eq("t4_stb_cycles", noack_cycles, ACK_TO);
    check_eq("t4_error", error, 1);
    check_eq("t4_cyc", wbm.wbm_cyc_o, 0);
    check_eq("t4_nwr", wr_adr.size(), 5);
    noack_idx = 8'hFF;

    // Reset in the middle of block writes (idx = 7)
    resp_clear();
    pulse_start(1'b1);
    feed(7, 0);
    n = 0;
    while (wr_adr.size() < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_at_idx7", wr_adr.size(), 7);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t5_rst");
    rst = 1'b0;
    resp_clear();
    pulse_start(1'b1);
    check_eq("t5_restart_adr", wbm.wbm_adr_o, BASE | 32'h09);
    feed(16, 0);
    wait_idle("t5_idle", 2000);
    check_writes("t5", 32'h1);
    check_digest("t5");

    // start_i during digest readout is ignored
    resp_clear();
    pulse_start(1'b1);
    feed(16, 0);
    n = 0;
    while (got_dig.size() < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_in_rd_dig", got_dig.size() >= 2, 1);
    pulse_start(1'b0);
    wait_idle("t6_idle", 2000);
    repeat (10) @(negedge clk);
    check_digest("t6");
    check_eq("t6_busy", busy, 0);
    check_eq("t6_cyc", wbm.wbm_cyc_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sha256_wb_initiator.md
# sha256_wb_initiator

Wishbone classic-cycle initiator that drives the SHA-256 core's register interface from the user-project side. It accepts a 16-word message block on a simple valid/ready stream and waits for core ready. It then writes the block and the init/next command, polls status until the digest is valid, and streams the 8 digest words back out. It sits between on-chip logic (or a logic-analyzer/IO bridge) and the SHA-256 responder, replacing the management SoC as bus master for self-test and standalone hashing.

## Interface
- `BASE_ADDR`, 32'h3000_0000: OR-ed into every bus address; the core register index occupies `wbm_adr_o[7:0]`, which is a word index, not a byte address.
- `ACK_TIMEOUT`, 255: maximum cycles `stb` may wait for `ack` before aborting.
- `POLL_LIMIT`, 1023: maximum STATUS reads per poll phase before aborting.
- `wb_clk_i  in  1`: single clock.
- `wb_rst_i  in  1`: synchronous, active-high reset.
- `start_i  in  1`: 1-cycle pulse; begins a hash of one block; ignored while `busy_o`.
- `first_i  in  1`: sampled with `start_i`; 1 selects init (CTRL=0x1), 0 selects next (CTRL=0x2).
- `blk_data_i  in  32`: message word; word 0 is most significant.
- `blk_valid_i  in  1`: message word valid.
- `blk_ready_o  out  1`: message word accepted when valid&ready.
- `dig_data_o  out  32`: digest word, H0 first.
- `dig_valid_o  out  1`: 1-cycle pulse per digest word.
- `dig_last_o  out  1`: high with the 8th `dig_valid_o`.
- `busy_o  out  1`: high from accepted `start_i` until return to IDLE.
- `error_o  out  1`: sticky abort flag; cleared by the next accepted `start_i`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o  out  1`: Wishbone master strobes.
- `wbm_adr_o  out  32`: bus address.
- `wbm_dat_o  out  32`: write data.
- `wbm_sel_o  out  4`: always 4'hF during a transfer.
- `wbm_dat_i  in  32`: read data.
- `wbm_ack_i  in  1`: transfer acknowledge.

## Operation
- Register map (word index): CTRL 0x08, STATUS 0x09 (bit0 ready, bit1 digest_valid), BLOCK0–15 0x10–0x1F, DIGEST0–7 0x20–0x27.
- FSM: IDLE → POLL_RDY → WR_BLK → WR_CTRL → POLL_DIG → RD_DIG → IDLE. Any timeout goes to ABORT → IDLE.
- POLL_RDY: read STATUS repeatedly until bit0=1.
- WR_BLK: `blk_ready_o`=1 only in WR_BLK while no transfer is in flight. An accepted word is captured, and a write to 0x10+idx is issued. The 4-bit idx increments on each ack; after the ack with idx=15, go to WR_CTRL.
- WR_CTRL: write 0x1 or 0x2 per the latched `first_i`.
- POLL_DIG: read STATUS until bit1=1.
- RD_DIG: read 0x20..0x27 in order. Each ack registers `wbm_dat_i` onto `dig_data_o` and pulses `dig_valid_o`. There is no output backpressure.
- ACK_TIMEOUT expiry or POLL_LIMIT reads without success: drop `cyc`/`stb` immediately, set `error_o`, return to IDLE.
- `start_i` while busy has no effect.

## Timing
- Reset values:
  - All bus outputs 0.
  - `blk_ready_o`, `dig_valid_o`, `dig_last_o`, `busy_o`, `error_o` = 0.
  - `dig_data_o` = 0.
  - FSM = IDLE; idx and all counters = 0.
- Reset mid-transfer drops `cyc`/`stb` on the same edge; no partial state survives.
- Wishbone classic only. `cyc`/`stb`/`we`/`adr`/`dat` are registered and held stable until the `ack` cycle. `stb` and `cyc` deassert on the edge after `ack`, leaving one idle cycle between transfers; there is no pipelining.
- `busy_o` rises on the edge after `start_i`; the first STATUS read `stb` is asserted on that same edge.
- A word accepted on edge N produces `stb` from N+1 with that data.
- `dig_valid_o` rises the edge after the `ack` that carried the word.
- `busy_o` falls the edge after the final DIGEST7 `ack`.
- The timeout counter resets on every new `stb` assertion. An `ack` arriving on the exact expiry cycle wins (the transfer completes).
- `ack` seen while `stb`=0 is ignored.

## Structure
- Package `sha256_wb_pkg` holds:
  - Register index constants (CTRL, STATUS, BLOCK_BASE, DIGEST_BASE).
  - STATUS bit positions.
  - CTRL command values.
  - The FSM state enum.
- One sub-module, `wb_master_port`, performs a single read or write transfer (req/done/timeout handshake, ack timeout counter). The FSM drives it.

## Test plan
- Responder model with 0-wait ack; block words 0x61626380, 0×14, 0x00000018, `first_i`=1 → 16 writes to 0x10–0x1F, CTRL=0x1, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, `dig_last_o` on the 8th word.
- Random ack latency 0–20 cycles with `blk_valid_i` gaps → identical writes and digest; `stb` held stable while waiting.
- STATUS digest_valid held 0 → exactly POLL_LIMIT STATUS reads, then `error_o`=1 and `busy_o`=0; the next `start_i` clears `error_o`.
- `ack` never returned on BLOCK5 write → `cyc` drops after ACK_TIMEOUT cycles and `error_o`=1.
- `wb_rst_i` asserted during WR_BLK idx=7 → next edge all outputs at reset values; a fresh start begins at BLOCK0.
- `start_i` pulsed during RD_DIG → ignored; exactly 8 digest pulses result.
